// File: rtl/biquad8_coeff_loader_if.sv
// Host staging-bank port plus the serial coefficient port towards the biquad8 DSP B cascade.
// Latency: none (wires only); backpressure: none, the host sees busy_o/pending_o as status.
// The master side drives writes and commits; the slave side is the loader.
interface biquad8_coeff_loader_if #(
    parameter int COEFF_BITS = 18,
    parameter int ADDR_BITS  = 4
);
    logic                  wr_en_i;
    logic [ADDR_BITS-1:0]  wr_addr_i;
    logic [COEFF_BITS-1:0] wr_dat_i;
    logic                  commit_i;
    logic                  busy_o;
    logic                  pending_o;
    logic                  done_o;
    logic [COEFF_BITS-1:0] coeff_dat_o;
    logic                  coeff_wr_o;
    logic                  coeff_update_o;

    modport master (
        output wr_en_i, wr_addr_i, wr_dat_i, commit_i,
        input  busy_o, pending_o, done_o, coeff_dat_o, coeff_wr_o, coeff_update_o
    );

    modport slave (
        input  wr_en_i, wr_addr_i, wr_dat_i, commit_i,
        output busy_o, pending_o, done_o, coeff_dat_o, coeff_wr_o, coeff_update_o
    );
endinterface

// File: rtl/biquad8_coeff_loader.sv
// Stages host coefficient writes, snapshots them on commit and shifts them out highest address first.
// Latency: first coeff_wr_o one cycle after commit, 2*NCOEFF+2 cycles per load.
// Backpressure: none; a commit while busy is queued one deep and further commits merge into it.
module biquad8_coeff_loader #(
    parameter int NCOEFF     = 2,
    parameter int COEFF_BITS = 18,
    parameter int ADDR_BITS  = 4
) (
    input  logic                 clk,
    input  logic                 rst,
    biquad8_coeff_loader_if.slave bus
);
    localparam int IDX_BITS = (NCOEFF > 1) ? $clog2(NCOEFF) : 1;
    localparam logic [IDX_BITS-1:0] LAST_IDX = IDX_BITS'(NCOEFF - 1);

    typedef logic [COEFF_BITS-1:0] coeff_t;
    typedef enum logic [2:0] {IDLE, WRITE, HOLD, UPDATE, FLUSH} state_t;

    state_t              state, state_nxt;
    coeff_t              bank     [NCOEFF];
    coeff_t              bank_nxt [NCOEFF];
    coeff_t              snap     [NCOEFF];
    logic [IDX_BITS-1:0] idx, idx_nxt;
    logic                pending, pending_nxt;
    logic                take_snap;
    logic                start;

    logic                busy_q, busy_nxt;
    logic                done_q, done_nxt;
    logic                wr_q, wr_nxt;
    logic                upd_q, upd_nxt;
    coeff_t              dat_q, dat_nxt;

    // Write-through view of the staging bank: a same-cycle write lands in the snapshot.
    always_comb begin
        for (int i = 0; i < NCOEFF; i++) begin
            bank_nxt[i] = (bus.wr_en_i && (bus.wr_addr_i == ADDR_BITS'(i))) ? bus.wr_dat_i : bank[i];
        end
    end

    assign start = bus.commit_i || pending;

    always_comb begin
        state_nxt   = state;
        idx_nxt     = idx;
        pending_nxt = pending;
        take_snap   = 1'b0;
        dat_nxt     = dat_q;

        if (bus.commit_i && (state != IDLE)) begin
            pending_nxt = 1'b1;
        end

        case (state)
            IDLE, FLUSH: begin
                if (start) begin
                    take_snap   = 1'b1;
                    idx_nxt     = LAST_IDX;
                    pending_nxt = 1'b0;
                    dat_nxt     = bank_nxt[NCOEFF-1];
                    state_nxt   = WRITE;
                end else begin
                    state_nxt   = IDLE;
                end
            end
            WRITE: begin
                state_nxt = HOLD;
            end
            // The filter registers its clock enable, so data stays put for one extra cycle.
            HOLD: begin
                if (idx == '0) begin
                    state_nxt = UPDATE;
                end else begin
                    idx_nxt   = idx - 1'b1;
                    dat_nxt   = snap[idx - 1'b1];
                    state_nxt = WRITE;
                end
            end
            UPDATE: begin
                state_nxt = FLUSH;
            end
            default: begin
                state_nxt = IDLE;
            end
        endcase

        busy_nxt = (state_nxt != IDLE);
        wr_nxt   = (state_nxt == WRITE);
        upd_nxt  = (state_nxt == UPDATE);
        done_nxt = (state_nxt == FLUSH);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state   <= IDLE;
            idx     <= '0;
            pending <= 1'b0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            wr_q    <= 1'b0;
            upd_q   <= 1'b0;
            dat_q   <= '0;
        end else begin
            state   <= state_nxt;
            idx     <= idx_nxt;
            pending <= pending_nxt;
            busy_q  <= busy_nxt;
            done_q  <= done_nxt;
            wr_q    <= wr_nxt;
            upd_q   <= upd_nxt;
            dat_q   <= dat_nxt;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < NCOEFF; i++) begin
                bank[i] <= '0;
                snap[i] <= '0;
            end
        end else begin
            for (int i = 0; i < NCOEFF; i++) begin
                bank[i] <= bank_nxt[i];
                if (take_snap) begin
                    snap[i] <= bank_nxt[i];
                end
            end
        end
    end

    assign bus.busy_o         = busy_q;
    assign bus.pending_o      = pending;
    assign bus.done_o         = done_q;
    assign bus.coeff_dat_o    = dat_q;
    assign bus.coeff_wr_o     = wr_q;
    assign bus.coeff_update_o = upd_q;
endmodule

// File: tb/tb_biquad8_coeff_loader.sv
// Scoreboarded bench for the coefficient loader at NCOEFF=2 and NCOEFF=16.
// Stimulus pushes expected strobes with their cycle numbers; monitors pop and compare.
module tb_biquad8_coeff_loader;
    localparam int CB = 18;
    localparam int AB = 4;

    typedef logic [CB-1:0] coeff_t;
    typedef struct {
        int     kind;   // 0 write strobe, 1 update, 2 done
        coeff_t dat;
        int     cyc;
    } ev_t;

    logic clk = 1'b0;
    logic rst = 1'b0;
    int   cyc = 0;
    int   checks = 0;
    int   errors = 0;
    ev_t  q2[$];
    ev_t  q16[$];

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    biquad8_coeff_loader_if #(.COEFF_BITS(CB), .ADDR_BITS(AB)) b2 ();
    biquad8_coeff_loader_if #(.COEFF_BITS(CB), .ADDR_BITS(AB)) b16 ();

    biquad8_coeff_loader #(.NCOEFF(2), .COEFF_BITS(CB), .ADDR_BITS(AB)) dut2 (
        .clk(clk), .rst(rst), .bus(b2)
    );
    biquad8_coeff_loader #(.NCOEFF(16), .COEFF_BITS(CB), .ADDR_BITS(AB)) dut16 (
        .clk(clk), .rst(rst), .bus(b16)
    );

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s at cycle %0d: got %h, expected %h", nm, cyc, act, exp);
        end
    endtask

    task automatic cmp(input string nm, input ev_t e, input int kind, input coeff_t dat);
        checks++;
        if (e.kind != kind || e.cyc != cyc || (kind == 0 && e.dat !== dat)) begin
            errors++;
            $display("FAIL %s: got kind %0d dat %h cycle %0d, expected kind %0d dat %h cycle %0d",
                     nm, kind, dat, cyc, e.kind, e.dat, e.cyc);
        end
    endtask

    task automatic take2(input int kind, input coeff_t dat);
        if (q2.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL spurious2: got kind %0d dat %h at cycle %0d, expected nothing", kind, dat, cyc);
        end else begin
            cmp("seq2", q2.pop_front(), kind, dat);
        end
    endtask

    task automatic take16(input int kind, input coeff_t dat);
        if (q16.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL spurious16: got kind %0d dat %h at cycle %0d, expected nothing", kind, dat, cyc);
        end else begin
            cmp("seq16", q16.pop_front(), kind, dat);
        end
    endtask

    logic   prev_wr2 = 1'b0, prev_wr16 = 1'b0;
    coeff_t prev_dat2 = '0, prev_dat16 = '0;

    always @(negedge clk) begin
        if (!rst) begin
            if (prev_wr2) check("hold2", 32'(b2.coeff_dat_o), 32'(prev_dat2));
            if (b2.coeff_wr_o) begin
                check("wr_upd_excl2", 32'(b2.coeff_update_o), 0);
                take2(0, b2.coeff_dat_o);
            end
            if (b2.coeff_update_o) take2(1, '0);
            if (b2.done_o) take2(2, '0);
        end
        prev_wr2  <= !rst && b2.coeff_wr_o;
        prev_dat2 <= b2.coeff_dat_o;
    end

    always @(negedge clk) begin
        if (!rst) begin
            if (prev_wr16) check("hold16", 32'(b16.coeff_dat_o), 32'(prev_dat16));
            if (b16.coeff_wr_o) begin
                check("wr_upd_excl16", 32'(b16.coeff_update_o), 0);
                take16(0, b16.coeff_dat_o);
            end
            if (b16.coeff_update_o) take16(1, '0);
            if (b16.done_o) take16(2, '0);
        end
        prev_wr16  <= !rst && b16.coeff_wr_o;
        prev_dat16 <= b16.coeff_dat_o;
    end

    task automatic step();
        @(negedge clk);
    endtask

    task automatic push2(input int k, input coeff_t d1, input coeff_t d0);
        q2.push_back('{0, d1, k + 1});
        q2.push_back('{0, d0, k + 3});
        q2.push_back('{1, '0, k + 5});
        q2.push_back('{2, '0, k + 6});
    endtask

    task automatic wr2(input int addr, input coeff_t d);
        b2.wr_en_i   = 1'b1;
        b2.wr_addr_i = AB'(addr);
        b2.wr_dat_i  = d;
        step();
        b2.wr_en_i   = 1'b0;
    endtask

    task automatic commit2();
        b2.commit_i = 1'b1;
        step();
        b2.commit_i = 1'b0;
    endtask

    task automatic wait_idle2();
        int n = 0;
        while (b2.busy_o && n < 200) begin
            step();
            n++;
        end
        if (n >= 200) begin
            checks++;
            errors++;
            $display("FAIL idle2_timeout: busy_o still 1 after %0d cycles, expected 0", n);
        end
    endtask

    task automatic wait_idle16();
        int n = 0;
        while (b16.busy_o && n < 200) begin
            step();
            n++;
        end
        if (n >= 200) begin
            checks++;
            errors++;
            $display("FAIL idle16_timeout: busy_o still 1 after %0d cycles, expected 0", n);
        end
    endtask

    initial begin
        int     k;
        coeff_t model[16];

        b2.wr_en_i = 1'b0;  b2.wr_addr_i = '0;  b2.wr_dat_i = '0;  b2.commit_i = 1'b0;
        b16.wr_en_i = 1'b0; b16.wr_addr_i = '0; b16.wr_dat_i = '0; b16.commit_i = 1'b0;

        // Reset state
        #1 rst = 1'b1;
        step();
        step();
        check("rst_busy", 32'(b2.busy_o), 0);
        check("rst_pending", 32'(b2.pending_o), 0);
        check("rst_done", 32'(b2.done_o), 0);
        check("rst_wr", 32'(b2.coeff_wr_o), 0);
        check("rst_upd", 32'(b2.coeff_update_o), 0);
        check("rst_dat", 32'(b2.coeff_dat_o), 0);
        check("rst_dat16", 32'(b16.coeff_dat_o), 0);
        rst = 1'b0;
        step();

        // Basic two-word load and busy window
        wr2(1, 18'h12345);
        wr2(0, 18'h00ABC);
        k = cyc;
        push2(k, 18'h12345, 18'h00ABC);
        commit2();
        for (int i = 1; i <= 6; i++) begin
            check("busy_seq", 32'(b2.busy_o), 1);
            step();
        end
        check("busy_after", 32'(b2.busy_o), 0);
        check("dat_after", 32'(b2.coeff_dat_o), 32'h00ABC);
        check("pending_after", 32'(b2.pending_o), 0);

        // Same-cycle write is snapshotted; later write is not
        k = cyc;
        push2(k, 18'h3FFFF, 18'h00ABC);
        b2.wr_en_i = 1'b1; b2.wr_addr_i = 4'd1; b2.wr_dat_i = 18'h3FFFF;
        b2.commit_i = 1'b1;
        step();
        b2.wr_en_i = 1'b0; b2.commit_i = 1'b0;
        step();
        wr2(0, 18'h11111);
        wait_idle2();
        k = cyc;
        push2(k, 18'h3FFFF, 18'h11111);
        commit2();
        wait_idle2();

        // Commits while busy merge into a single queued sequence
        k = cyc;
        push2(k, 18'h3FFFF, 18'h11111);
        push2(k + 6, 18'h3FFFF, 18'h11111);
        commit2();
        step();
        check("pending_c2", 32'(b2.pending_o), 0);
        commit2();
        check("pending_c3", 32'(b2.pending_o), 1);
        step();
        commit2();
        check("pending_c5", 32'(b2.pending_o), 1);
        step();
        check("pending_c6", 32'(b2.pending_o), 1);
        step();
        check("pending_c7", 32'(b2.pending_o), 0);
        check("busy_c7", 32'(b2.busy_o), 1);
        wait_idle2();

        // Out-of-range write ignored; commit in FLUSH chains with no gap
        wr2(5, 18'h2AAAA);
        k = cyc;
        push2(k, 18'h3FFFF, 18'h11111);
        commit2();
        repeat (5) step();
        push2(k + 6, 18'h3FFFF, 18'h11111);
        commit2();
        check("busy_chain", 32'(b2.busy_o), 1);
        check("wr_chain", 32'(b2.coeff_wr_o), 1);
        wait_idle2();

        // Asynchronous reset mid-sequence
        k = cyc;
        q2.push_back('{0, 18'h3FFFF, k + 1});
        commit2();
        step();
        @(posedge clk);
        #2 rst = 1'b1;
        #1;
        check("arst_busy", 32'(b2.busy_o), 0);
        check("arst_wr", 32'(b2.coeff_wr_o), 0);
        check("arst_upd", 32'(b2.coeff_update_o), 0);
        check("arst_done", 32'(b2.done_o), 0);
        check("arst_dat", 32'(b2.coeff_dat_o), 0);
        step();
        step();
        rst = 1'b0;
        repeat (4) step();
        check("q2_after_rst", 32'(q2.size()), 0);
        k = cyc;
        push2(k, 18'h00000, 18'h00000);
        commit2();
        wait_idle2();

        // Sixteen-word load
        for (int i = 0; i < 16; i++) begin
            model[i] = 18'($urandom_range(0, 18'h3FFFF));
            b16.wr_en_i = 1'b1; b16.wr_addr_i = AB'(i); b16.wr_dat_i = model[i];
            step();
        end
        b16.wr_en_i = 1'b0;
        k = cyc;
        for (int j = 0; j < 16; j++) q16.push_back('{0, model[15-j], k + 1 + 2*j});
        q16.push_back('{1, '0, k + 33});
        q16.push_back('{2, '0, k + 34});
        b16.commit_i = 1'b1;
        step();
        b16.commit_i = 1'b0;
        wait_idle16();

        repeat (3) step();
        check("q2_drained", 32'(q2.size()), 0);
        check("q16_drained", 32'(q16.size()), 0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule

// File: doc/biquad8_coeff_loader.md
Name: biquad8_coeff_loader

Overview:
- Transmitter side of the biquad coefficient port (18-bit data, write strobe, update strobe) that feeds the DSP48E2 B-register cascade in the biquad8 filters.
- The host writes coefficients into a staging bank at random addresses, then issues a commit.
- The block snapshots the bank and shifts the words out highest address first, each word with a write strobe.
- It then pulses the update strobe so every DSP transfers B1 to B2 at the same time.

Parameters:
- NCOEFF, 2, number of coefficient words per load; legal range 1-16 (the filter cascade uses 2: high DSP, then low DSP).
- COEFF_BITS, 18, coefficient width; matches the DSP B port.
- ADDR_BITS, 4, width of the host address; must satisfy 2^ADDR_BITS >= NCOEFF.

Ports:
- clk  in  1  single system clock.
- rst  in  1  asynchronous, active-high reset.
- wr_en_i  in  1  host staging-bank write enable.
- wr_addr_i  in  ADDR_BITS  staging-bank address.
- wr_dat_i  in  COEFF_BITS  staging-bank data.
- commit_i  in  1  one-cycle request to load the staging bank into the filter.
- busy_o  out  1  high while a load sequence is running.
- pending_o  out  1  high while a commit is queued behind the running sequence.
- done_o  out  1  one-cycle pulse in the last cycle of a sequence.
- coeff_dat_o  out  COEFF_BITS  to filter coeff_dat_i.
- coeff_wr_o  out  1  to filter coeff_wr_i.
- coeff_update_o  out  1  to filter coeff_update_i.

Behaviour:
- Reset (asynchronous, any state, any time):
  - All outputs go to 0; the FSM goes to IDLE.
  - Staging bank, snapshot bank, index and pending flag are cleared to 0.
  - A sequence interrupted by reset never asserts coeff_update_o. The filter keeps its old B2 coefficients; its B1 may be partly shifted.
- Staging writes:
  - On wr_en_i, bank[wr_addr_i] <= wr_dat_i.
  - A write with wr_addr_i >= NCOEFF is ignored.
  - Writes are accepted in every state, including while busy.
- Snapshot:
  - When a sequence starts, all NCOEFF staging words are copied in parallel into the snapshot bank.
  - A write in the same cycle as the start is included in the snapshot (write-through).
  - Later writes never affect the running sequence.
- All outputs are registered. The FSM has five states: IDLE, WRITE, HOLD, UPDATE, FLUSH.
  - IDLE: commit_i, or a set pending flag, starts a sequence. Take the snapshot, set idx = NCOEFF-1, go to WRITE.
  - WRITE (1 cycle): coeff_wr_o = 1, coeff_dat_o = snap[idx]. Go to HOLD.
  - HOLD (1 cycle): coeff_wr_o = 0 and coeff_dat_o is still snap[idx], because the filter registers its clock-enable one cycle later. If idx = 0 go to UPDATE; otherwise decrement idx and go to WRITE.
  - UPDATE (1 cycle): coeff_update_o = 1. Go to FLUSH.
  - FLUSH (1 cycle): done_o = 1, covering the filter's registered update enable. Go to IDLE; if pending, go directly to a new sequence (snapshot taken at that transition).
- Timing:
  - busy_o = 1 in every state except IDLE.
  - If commit_i is sampled at edge k, busy_o and the first coeff_wr_o appear in cycle k+1.
  - Sequence length is 2*NCOEFF+2 cycles: coeff_update_o in cycle k+2*NCOEFF+1, done_o in cycle k+2*NCOEFF+2.
  - coeff_dat_o holds its last value after the sequence; it is 0 after reset.
- Commit while busy:
  - Sets pending (one level only; extra commits merge into it). pending_o reflects the flag.
  - The pending flag clears when the queued sequence starts.
  - A commit in the FLUSH cycle is also queued: the next sequence starts with no IDLE gap (busy_o stays high, done_o pulses once per sequence).
- coeff_wr_o and coeff_update_o are never high in the same cycle. Consecutive coeff_wr_o pulses are exactly 2 cycles apart.

Test Plan:
- NCOEFF=2; write bank[1]=0x12345, bank[0]=0x00ABC; commit at edge 0 -> coeff_wr_o high in cycles 1 and 3; coeff_dat_o=0x12345 in cycles 1-2 and 0x00ABC in cycles 3-4; coeff_update_o in cycle 5; done_o in cycle 6; busy_o high in cycles 1-6.
- Write bank[1]=0x3FFFF in the same cycle as commit -> first word sent is 0x3FFFF. Write bank[0]=0x11111 at cycle 2 -> second word is still the old value; a later commit sends 0x11111.
- Commit at cycle 0, then again at cycles 2 and 4 -> pending_o high from cycle 3; exactly one extra sequence; second coeff_wr_o train starts at cycle 7 with no IDLE gap; done_o pulses at cycles 6 and 12.
- wr_addr_i=5 (NCOEFF=2) with data 0x2AAAA -> bank unchanged; the following commit sends the previous values.
- Assert rst in cycle 3 of a sequence -> all outputs 0 immediately (asynchronous); no coeff_update_o; after release a commit sends 0x00000 for both words.
- NCOEFF=16, random data -> 16 write strobes from address 15 down to 0, update at k+33, done at k+34.
